// File: rtl/ps2_calc_display_if.sv
// rtl/ps2_calc_display_if.sv - keypad result input and display/status outputs of the display stage
// The driver side presents the result word; the display side owns every output.
interface ps2_calc_display_if;
  logic [31:0] data_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [15:0] bcd_out;
  logic        ovf;
  logic        busy;

  modport master (
    output data_in,
    input  seg,
    input  an,
    input  dp,
    input  bcd_out,
    input  ovf,
    input  busy
  );

  modport slave (
    input  data_in,
    output seg,
    output an,
    output dp,
    output bcd_out,
    output ovf,
    output busy
  );
endinterface

// File: rtl/ps2_calc_display.sv
// rtl/ps2_calc_display.sv - iterative binary-to-BCD conversion driving a 4-digit multiplexed 7-segment display
// Conversion is started in IDLE by a new valid value; the scan runs free of the converter.
module ps2_calc_display #(
  parameter int REFRESH_DIV = 50000
) (
  input logic                  clk,
  input logic                  rst,
  ps2_calc_display_if.slave    bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [1:0]    state;
  logic [34:0]   shreg;
  logic [34:0]   shreg_next;
  logic [3:0]    iter;
  logic [14:0]   last_val;
  logic          shown;
  logic          done_seen;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic          trigger;
  logic [3:0]    nibble;
  logic          lead_blank;
  logic [6:0]    seg_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = SEG_BLANK;
    endcase
  endfunction

  assign trigger  = (state == ST_IDLE) && bus.data_in[15] &&
                    (!shown || (bus.data_in[14:0] != last_val));
  assign bus.busy = (state != ST_IDLE);
  assign bus.dp   = 1'b1;

  // Add-3 on all five BCD nibbles, then shift the whole register left by one.
  always_comb begin
    logic [34:0] adj;
    adj = shreg;
    for (int i = 0; i < 5; i++) begin
      if (adj[15 + 4*i +: 4] >= 4'd5) begin
        adj[15 + 4*i +: 4] = adj[15 + 4*i +: 4] + 4'd3;
      end
    end
    shreg_next = {adj[33:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      iter        <= '0;
      last_val    <= '0;
      shown       <= 1'b0;
      done_seen   <= 1'b0;
      bus.bcd_out <= '0;
      bus.ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            shreg    <= {20'b0, bus.data_in[14:0]};
            last_val <= bus.data_in[14:0];
            shown    <= 1'b1;
            iter     <= '0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg <= shreg_next;
          iter  <= iter + 4'd1;
          if (iter == 4'd14) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          bus.bcd_out <= shreg[30:15];
          bus.ovf     <= (last_val > 15'd9999);
          done_seen   <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // A digit above the units is blank when it and every higher digit are zero.
  always_comb begin
    nibble = bus.bcd_out[4*digit_idx +: 4];
    case (digit_idx)
      2'd3:    lead_blank = (bus.bcd_out[15:12] == 4'd0);
      2'd2:    lead_blank = (bus.bcd_out[15:8] == 8'd0);
      2'd1:    lead_blank = (bus.bcd_out[15:4] == 12'd0);
      default: lead_blank = 1'b0;
    endcase
    if (!shown || !done_seen) begin
      seg_next = SEG_BLANK;
    end else if (bus.ovf) begin
      seg_next = SEG_DASH;
    end else if (lead_blank) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = decode(nibble);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.seg <= SEG_BLANK;
      bus.an  <= 4'hF;
    end else begin
      bus.seg <= seg_next;
      bus.an  <= ~(4'b0001 << digit_idx);
    end
  end

endmodule

// File: tb/tb_ps2_calc_display.sv
// tb/tb_ps2_calc_display.sv - directed self-checking bench for ps2_calc_display
module tb_ps2_calc_display;
  localparam int RDIV = 4;

  logic clk;
  logic rst;
  ps2_calc_display_if bus();

  ps2_calc_display #(.REFRESH_DIV(RDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    logic [15:0] bcd;
    logic        ovf;
    logic [6:0]  seg [4];
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for busy to rise, then returns how many sampled cycles it stayed high.
  task automatic measure_busy(output int cycles, output bit seen);
    seen = 0;
    cycles = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (bus.busy) seen = 1;
    end
    if (seen) begin
      cycles = 1;
      for (int i = 0; i < 40 && bus.busy; i++) begin
        @(negedge clk);
        if (bus.busy) cycles++;
      end
    end
  endtask

  task automatic check_digit(input string name, input int k, input logic [6:0] exp_seg);
    logic [3:0] target;
    bit found;
    target = ~(4'b0001 << k);
    found = 0;
    for (int i = 0; i < 6 * RDIV && !found; i++) begin
      @(negedge clk);
      if (bus.an == target) found = 1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: anode %h never reached", name, target);
    end else begin
      chk(name, {25'd0, bus.seg}, {25'd0, exp_seg});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    bit seen;
    bit quiet;
    bit found;

    vecs[0] = '{32'h0000_84D2, 16'h1234, 1'b0, '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}};
    vecs[1] = '{32'h0000_8007, 16'h0007, 1'b0, '{7'b1111000, 7'h7F, 7'h7F, 7'h7F}};
    vecs[2] = '{32'h0000_8000, 16'h0000, 1'b0, '{7'b1000000, 7'h7F, 7'h7F, 7'h7F}};
    vecs[3] = '{32'hFFFF_8131, 16'h0305, 1'b0, '{7'b0010010, 7'b1000000, 7'b0110000, 7'h7F}};
    vecs[4] = '{32'h0000_A710, 16'h0000, 1'b1, '{7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
    vecs[5] = '{32'h0000_B039, 16'h2345, 1'b1, '{7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};

    rst = 1'b0;
    bus.data_in = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_seg", {25'd0, bus.seg}, 32'h7F);
    chk("reset_an", {28'd0, bus.an}, 32'hF);
    chk("reset_dp", {31'd0, bus.dp}, 32'h1);
    chk("reset_bcd", {16'd0, bus.bcd_out}, 32'h0);
    chk("reset_ovf", {31'd0, bus.ovf}, 32'h0);
    chk("reset_busy", {31'd0, bus.busy}, 32'h0);
    rst = 1'b1;

    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (bus.an == 4'hE) found = 1;
    end
    chk("scan_start", {31'd0, found}, 32'h1);
    for (int i = 0; i < 4 * RDIV; i++) begin
      logic [3:0] exp_an;
      exp_an = ~(4'b0001 << (i / RDIV));
      chk($sformatf("scan_an_%0d", i), {28'd0, bus.an}, {28'd0, exp_an});
      chk($sformatf("scan_blank_%0d", i), {25'd0, bus.seg}, 32'h7F);
      @(negedge clk);
    end

    foreach (vecs[v]) begin
      @(posedge clk);
      #1 bus.data_in = vecs[v].data;
      measure_busy(cyc, seen);
      chk($sformatf("v%0d_busy_seen", v), {31'd0, seen}, 32'h1);
      chk($sformatf("v%0d_busy_len", v), cyc, 32'd16);
      chk($sformatf("v%0d_bcd", v), {16'd0, bus.bcd_out}, {16'd0, vecs[v].bcd});
      chk($sformatf("v%0d_ovf", v), {31'd0, bus.ovf}, {31'd0, vecs[v].ovf});
      for (int k = 0; k < 4; k++) begin
        check_digit($sformatf("v%0d_digit%0d", v, k), k, vecs[v].seg[k]);
      end
      quiet = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.busy) quiet = 0;
      end
      chk($sformatf("v%0d_no_retrigger", v), {31'd0, quiet}, 32'h1);
    end

    // New value presented mid-conversion is picked up only after DONE.
    @(posedge clk);
    #1 bus.data_in = 32'h0000_802A;
    @(posedge clk);
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk);
      if (i == 5) #1 bus.data_in = 32'h0000_8063;
      if (i == 15) begin
        @(negedge clk);
        chk("midchg_busy_t15", {31'd0, bus.busy}, 32'h1);
      end
      if (i == 16) begin
        @(negedge clk);
        chk("midchg_bcd_42", {16'd0, bus.bcd_out}, 32'h0042);
        chk("midchg_busy_t16", {31'd0, bus.busy}, 32'h0);
      end
      if (i == 17) begin
        @(negedge clk);
        chk("midchg_retrigger", {31'd0, bus.busy}, 32'h1);
      end
      if (i == 32) begin
        @(negedge clk);
        chk("midchg_bcd_hold", {16'd0, bus.bcd_out}, 32'h0042);
      end
      if (i == 33) begin
        @(negedge clk);
        chk("midchg_bcd_99", {16'd0, bus.bcd_out}, 32'h0099);
      end
    end

    // Reset in the middle of a conversion discards it; release re-triggers.
    repeat (3) @(posedge clk);
    #1 bus.data_in = 32'h0000_962E;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'h0);
    chk("midrst_bcd", {16'd0, bus.bcd_out}, 32'h0);
    chk("midrst_ovf", {31'd0, bus.ovf}, 32'h0);
    chk("midrst_seg", {25'd0, bus.seg}, 32'h7F);
    chk("midrst_an", {28'd0, bus.an}, 32'hF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    measure_busy(cyc, seen);
    chk("midrst_retrig", {31'd0, seen}, 32'h1);
    chk("midrst_busy_len", cyc, 32'd16);
    chk("midrst_bcd_5678", {16'd0, bus.bcd_out}, 32'h5678);
    chk("midrst_ovf_after", {31'd0, bus.ovf}, 32'h0);
    check_digit("midrst_digit3", 3, 7'b0010010);

    // Clearing the valid bit must not blank the display.
    @(posedge clk);
    #1 bus.data_in = 32'h0000_0000;
    check_digit("invalid_keeps_digit0", 0, 7'b0000000);
    chk("invalid_bcd", {16'd0, bus.bcd_out}, 32'h5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_calc_display.md
# ps2_calc_display

Downstream display stage for the PS/2 calculator keypad front-end. Takes the 32-bit result word the keypad decoder produces (bit 15 = value valid, bits 14:0 = binary value) and converts the value to four BCD digits with an iterative double-dabble engine. Drives a multiplexed, active-low, 4-digit seven-segment display, with leading-zero blanking and an overflow indication.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays lit; 1 kHz per digit at 50 MHz. Minimum 2.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  32  keypad result word. Bit 15 = valid, bits 14:0 = unsigned value. Bits 31:16 ignored.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit enables, active-low. an[0] = units (rightmost).
- dp  output  1  decimal point, active-low, held 1.
- bcd_out  output  16  last converted value as 4 BCD nibbles, thousands in [15:12].
- ovf  output  1  last converted value was greater than 9999.
- busy  output  1  conversion in progress.

## Operation
- Reset values: seg=7'h7F, an=4'hF, dp=1, bcd_out=0, ovf=0, busy=0. Internal state also clears: last_val=0, shown=0, refresh counter=0, digit index=0. FSM returns to IDLE.
- **Trigger**: evaluated only in IDLE. Fires when data_in[15]=1 and (shown=0 or data_in[14:0]≠last_val).
- **FSM**
  - IDLE: on trigger, load shift register {20'b0, data_in[14:0]}, set last_val=data_in[14:0], shown=1, iteration count=0, then go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5 (five nibbles, 20 bits), then shift left 1. After the 15th iteration go to DONE.
  - DONE: for one cycle, write bcd_out = low 4 BCD nibbles and ovf = (last_val>9999). Return to IDLE.
- busy = (state≠IDLE).
- **Value change mid-conversion**: the conversion in progress is not restarted. The new value is picked up by the trigger on the first IDLE cycle after DONE.
- data_in[15]=0 never clears the display; it only suppresses triggers.
- **Scan**
  - Refresh counter runs 0..REFRESH_DIV-1, free-running from reset. On wrap, digit index advances 0→1→2→3→0.
  - an = one-hot low at the digit index; an[0] is lit when index=0.
- **Digit content**
  - shown=0, or no DONE yet since reset: seg=7'h7F on all digits (blank). The anode scan still runs.
  - ovf=1: every digit shows dash, seg=7'b0111111.
  - Otherwise: digit k shows its bcd_out nibble. Digit k (k≥1) is blanked (seg=7'h7F) when that nibble and all higher nibbles are 0. Digit 0 is never blanked after the first DONE.
- **Decode** (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- seg and an are registered from the same index, so they always switch on the same edge.

## Timing
- Edge T samples a trigger in IDLE. busy goes high after T.
- SHIFT occupies edges T+1..T+15. DONE is edge T+16.
- bcd_out and ovf update at edge T+16. busy drops after T+16.
- Next possible trigger is edge T+17. Latency from trigger to display is 16 cycles, plus up to one scan slot before a given digit shows it.
- Scan: each digit is lit for exactly REFRESH_DIV cycles. A full frame is 4×REFRESH_DIV cycles.
- rst assertion mid-SHIFT: immediate return to reset values and the partial result is discarded. After release, a still-valid data_in re-triggers, because shown=0.
- **Width rules**
  - Max input 32767, hence the 5th nibble in the shifter.
  - ovf is the comparison last_val>9999. bcd_out then holds the low 4 BCD digits of the value, e.g. 12345 gives 0x2345.

## Test plan
- Reset with rst=0 for 3 cycles, data_in=0 → seg=7F, an=F, dp=1, bcd_out=0, ovf=0, busy=0. After release, with REFRESH_DIV=4, an cycles E,D,B,7 every 4 cycles with seg=7F throughout.
- data_in=32'h0000_84D2 (valid, 1234) → busy high for 16 cycles, then bcd_out=16'h1234, ovf=0. Scan shows an=E:0011001 ('4'), D:0110000 ('3'), B:0100100 ('2'), 7:1111001 ('1').
- data_in=32'h0000_8007 (7) → bcd_out=0x0007. an=E shows 1111000; an=D/B/7 show 7F. Then data_in=32'h0000_8000 → bcd_out=0x0000, digit 0 shows 1000000, others blank.
- data_in=32'h0000_A710 (10000) → ovf=1, bcd_out=0x0000, all four digits show 0111111. Holding the same word produces no further busy pulse.
- Value 42, then 99 presented 5 cycles after the trigger → bcd_out=0x0042 at T+16. A second conversion triggers at T+17 and bcd_out=0x0099 at T+33.
- Value 5678, rst pulsed low at T+8 → outputs return to reset values at once with no bcd_out write. After release, a fresh conversion yields bcd_out=0x5678 16 cycles after the re-trigger.
